// File: rtl/dct_pkg.sv
// Shared types and constants for the 8x8 2-D DCT sequencer.
// One butterfly pipeline is time-shared between the row and column passes.
package dct_pkg;

    localparam int DATA_W       = 32;
    localparam int N            = 8;
    localparam int BFLY_LATENCY = 5;
    localparam int IDX_W        = 3;

    typedef logic [N-1:0][DATA_W-1:0] row_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_ROWS,
        S_DRAIN_ROWS,
        S_ISSUE_COLS,
        S_DRAIN_COLS,
        S_OUTPUT
    } seq_state_t;

    localparam logic PASS_ROW = 1'b0;
    localparam logic PASS_COL = 1'b1;

    typedef struct packed {
        logic             valid;
        logic             pass;
        logic [IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/dct_transpose_buf.sv
// 8x8 word store: whole-row write, combinational row or column read.
// Contents are not reset; a block always rewrites every row before use.
module dct_transpose_buf
    import dct_pkg::*;
(
    input  logic             CLOCK,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  row_t             wr_data_i,
    input  logic             col_rd_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output row_t             rd_data_o
);

    logic [DATA_W-1:0] mem_q [N][N];

    // Store one full row per write
    always_ff @(posedge CLOCK) begin
        if (we_i) begin
            for (int j = 0; j < N; j++) begin
                mem_q[wr_idx_i][j] <= wr_data_i[j];
            end
        end
    end

    // Lane j returns element [j][idx] (column) or [idx][j] (row)
    always_comb begin
        rd_data_o = '0;
        for (int j = 0; j < N; j++) begin
            if (col_rd_i) begin
                rd_data_o[j] = mem_q[j][rd_idx_i];
            end else begin
                rd_data_o[j] = mem_q[rd_idx_i][j];
            end
        end
    end

endmodule

// File: rtl/dct_2d_sequencer.sv
// Runs rows then columns of an 8x8 block through one external butterfly.
// A tag pipeline matched to the butterfly depth says where each result goes.
module dct_2d_sequencer
    import dct_pkg::*;
(
    input  logic                       CLOCK,
    input  logic                       RESET,
    input  logic [N-1:0][DATA_W-1:0]   IN_DATA,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    output logic [N-1:0][DATA_W-1:0]   BF_DATA,
    input  logic [N-1:0][DATA_W-1:0]   BF_OUT,
    output logic [N-1:0][DATA_W-1:0]   OUT_DATA,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic                       BUSY
);

    localparam int TAG_D = BFLY_LATENCY + 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    seq_state_t       state_q;
    logic [IDX_W:0]   row_cnt_q;
    logic [IDX_W-1:0] col_cnt_q;
    logic [IDX_W-1:0] out_cnt_q;
    row_t             bf_data_q;
    logic             out_valid_q;
    tag_t             tag_q [TAG_D];

    logic in_fire;
    logic out_fire;
    tag_t tag_d;
    tag_t tag_out;
    logic rb_we;
    logic cb_we;
    row_t rb_col;
    row_t cb_col;

    assign IN_READY = (state_q == S_IDLE) ||
                      ((state_q == S_LOAD_ROWS) &&
                       (row_cnt_q < (IDX_W+1)'(N)));
    assign in_fire  = IN_VALID & IN_READY;
    assign out_fire = out_valid_q & OUT_READY;
    assign tag_out  = tag_q[TAG_D-1];
    assign rb_we    = tag_out.valid & (tag_out.pass == PASS_ROW);
    assign cb_we    = tag_out.valid & (tag_out.pass == PASS_COL);

    assign BF_DATA   = bf_data_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_valid_q ? cb_col : '0;
    assign BUSY      = (state_q != S_IDLE);

    // Tag entering the pipeline alongside each butterfly issue
    always_comb begin
        tag_d = '0;
        if (in_fire) begin
            tag_d = '{valid: 1'b1, pass: PASS_ROW,
                      idx: row_cnt_q[IDX_W-1:0]};
        end else if (state_q == S_ISSUE_COLS) begin
            tag_d = '{valid: 1'b1, pass: PASS_COL, idx: col_cnt_q};
        end
    end

    // Tag shift register tracking results through the butterfly
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            for (int i = 0; i < TAG_D; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i < TAG_D; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Row results; columns are read out of it during issue
    dct_transpose_buf u_row_buf (
        .CLOCK     (CLOCK),
        .we_i      (rb_we),
        .wr_idx_i  (tag_out.idx),
        .wr_data_i (BF_OUT),
        .col_rd_i  (1'b1),
        .rd_idx_i  (col_cnt_q),
        .rd_data_o (rb_col)
    );

    // Column results stored transposed; a column read gives an output row
    dct_transpose_buf u_col_buf (
        .CLOCK     (CLOCK),
        .we_i      (cb_we),
        .wr_idx_i  (tag_out.idx),
        .wr_data_i (BF_OUT),
        .col_rd_i  (1'b1),
        .rd_idx_i  (out_cnt_q),
        .rd_data_o (cb_col)
    );

    // Block sequencing FSM with registered butterfly operand and valid
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            row_cnt_q   <= '0;
            col_cnt_q   <= '0;
            out_cnt_q   <= '0;
            bf_data_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (in_fire) begin
                bf_data_q <= IN_DATA;
                row_cnt_q <= row_cnt_q + 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (in_fire) begin
                        state_q <= S_LOAD_ROWS;
                    end
                end
                S_LOAD_ROWS: begin
                    if (in_fire &&
                        row_cnt_q == (IDX_W+1)'(N - 1)) begin
                        state_q <= S_DRAIN_ROWS;
                    end
                end
                S_DRAIN_ROWS: begin
                    if (rb_we && tag_out.idx == LAST) begin
                        state_q   <= S_ISSUE_COLS;
                        col_cnt_q <= '0;
                        row_cnt_q <= '0;
                    end
                end
                S_ISSUE_COLS: begin
                    bf_data_q <= rb_col;
                    col_cnt_q <= col_cnt_q + 1'b1;
                    if (col_cnt_q == LAST) begin
                        state_q <= S_DRAIN_COLS;
                    end
                end
                S_DRAIN_COLS: begin
                    if (cb_we && tag_out.idx == LAST) begin
                        state_q     <= S_OUTPUT;
                        out_cnt_q   <= '0;
                        out_valid_q <= 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (out_fire) begin
                        out_cnt_q <= out_cnt_q + 1'b1;
                        if (out_cnt_q == LAST) begin
                            state_q     <= S_IDLE;
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
